// File: rtl/ad79x8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ad79x8_pkg
//  Description : Shared constants for the AD79X8 control/result word layout
//                and the sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package ad79x8_pkg;

    // Control word bit positions
    localparam int c_cw_write      = 15;
    localparam int c_cw_seq        = 14;
    localparam int c_cw_add_msb    = 12;
    localparam int c_cw_add_lsb    = 10;
    localparam int c_cw_pm_msb     = 9;
    localparam int c_cw_pm_lsb     = 8;
    localparam int c_cw_shadow     = 7;
    localparam int c_cw_range      = 5;
    localparam int c_cw_coding     = 4;

    localparam logic [1:0] c_pm_normal = 2'b11;

    // Result word field positions
    localparam int c_rs_err        = 15;
    localparam int c_rs_id_msb     = 14;
    localparam int c_rs_id_lsb     = 12;
    localparam int c_rs_data_msb   = 11;

    // Sequencer states
    typedef logic [2:0] seq_state_t;
    localparam seq_state_t c_st_wait_idle = 3'd0;
    localparam seq_state_t c_st_start     = 3'd1;
    localparam seq_state_t c_st_busy      = 3'd2;
    localparam seq_state_t c_st_settle    = 3'd3;
    localparam seq_state_t c_st_capture   = 3'd4;
    localparam seq_state_t c_st_next      = 3'd5;
    localparam seq_state_t c_st_idle      = 3'd6;

    // Normal-mode single-channel control word for channel add
    function automatic logic [15:0] ctrl_word(input logic [2:0] add,
                                              input logic       range,
                                              input logic       coding);
        logic [15:0] w;
        w                             = '0;
        w[c_cw_write]                 = 1'b1;
        w[c_cw_seq]                   = 1'b0;
        w[c_cw_add_msb:c_cw_add_lsb]  = add;
        w[c_cw_pm_msb:c_cw_pm_lsb]    = c_pm_normal;
        w[c_cw_shadow]                = 1'b0;
        w[c_cw_range]                 = range;
        w[c_cw_coding]                = coding;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad79x8_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ad79x8_sequencer_if
//  Description : Frame handshake between the sequencer and the AD79X8 serial
//                interface block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ad79x8_sequencer_if;
    logic        adc_initiate;
    logic [15:0] adc_word;
    logic [15:0] adc_result;
    logic        adc_cs;

    modport master (output adc_initiate, output adc_word,
                    input  adc_result,   input  adc_cs);
    modport slave  (input  adc_initiate, input  adc_word,
                    output adc_result,   output adc_cs);
endinterface
`default_nettype wire

// File: rtl/ad79x8_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : ad79x8_rr_pick
//  Description : Round-robin channel picker: lowest set mask bit strictly
//                above cur, wrapping 7 -> 0; cur itself if it is the only one.
//  Revision    : 1.0 - initial release
// ============================================================================
module ad79x8_rr_pick (
    input  logic [2:0] cur,
    input  logic [7:0] mask,
    output logic [2:0] next,
    output logic       none
);

    logic [2:0] w_idx;

    // Scan from farthest to nearest so the nearest enabled channel wins
    always_comb begin
        next  = cur;
        none  = (mask == 8'h00);
        w_idx = '0;
        for (int k = 8; k >= 1; k--) begin
            w_idx = cur + 3'(k);
            if (mask[w_idx]) begin
                next = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ad79x8_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ad79x8_sequencer
//  Description : Drives the AD79X8 interface block: power-up dummy frames,
//                round-robin control words, result decode and result bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module ad79x8_sequencer
    import ad79x8_pkg::*;
#(
    parameter int          RES_BITS   = 12,
    parameter logic [15:0] DUMMY_WORD = 16'hFFFF,
    parameter int          N_DUMMY    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic [7:0]              en_mask,
    input  logic                    cfg_range,
    input  logic                    cfg_coding,
    input  logic                    ch_clr,
    ad79x8_sequencer_if.master      bus,
    output logic                    ready,
    output logic                    res_valid,
    output logic [2:0]              res_ch,
    output logic [RES_BITS-1:0]     res_data,
    output logic [8*RES_BITS-1:0]   ch_data,
    output logic [7:0]              ch_valid,
    output logic                    frame_err
);

    localparam logic [7:0] c_dummy_frames = 8'(N_DUMMY);

    seq_state_t          r_state;
    logic                r_cs_q;
    logic [7:0]          r_dummy_cnt;
    logic                r_first;
    logic [2:0]          r_cur;

    logic [2:0]          w_next_ch;
    logic                w_none;
    logic                w_in_dummy;
    logic                w_capture;
    logic [2:0]          w_id;
    logic [RES_BITS-1:0] w_data;
    logic [7:0]          w_valid_kept;

    ad79x8_rr_pick u_pick (
        .cur  (r_cur),
        .mask (en_mask),
        .next (w_next_ch),
        .none (w_none)
    );

    assign w_in_dummy   = (r_dummy_cnt < c_dummy_frames);
    // The first normal frame returns a conversion requested before this run
    assign w_capture    = (r_state == c_st_capture) && !w_in_dummy && !r_first;
    assign w_id         = bus.adc_result[c_rs_id_msb:c_rs_id_lsb];
    assign w_data       = bus.adc_result[c_rs_data_msb -: RES_BITS];
    assign w_valid_kept = ch_clr ? 8'h00 : ch_valid;

    // Frame sequencing: dummy phase, word selection and initiate handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= c_st_wait_idle;
            r_cs_q           <= 1'b0;
            r_dummy_cnt      <= '0;
            r_first          <= 1'b1;
            r_cur            <= 3'd7;
            ready            <= 1'b0;
            bus.adc_initiate <= 1'b0;
            bus.adc_word     <= DUMMY_WORD;
        end else begin
            r_cs_q <= bus.adc_cs;
            case (r_state)
                c_st_wait_idle: begin
                    // Interface block has no reset and may still be mid-frame
                    if (bus.adc_cs) begin
                        r_state          <= c_st_start;
                        bus.adc_initiate <= 1'b1;
                    end
                end
                c_st_start: begin
                    if (!bus.adc_cs) begin
                        r_state          <= c_st_busy;
                        bus.adc_initiate <= 1'b0;
                    end
                end
                c_st_busy: begin
                    if (bus.adc_cs && !r_cs_q) begin
                        r_state <= c_st_settle;
                    end
                end
                c_st_settle: begin
                    r_state <= c_st_capture;
                end
                c_st_capture: begin
                    r_state <= c_st_next;
                    if (w_in_dummy) begin
                        r_dummy_cnt <= r_dummy_cnt + 8'd1;
                    end else if (r_first) begin
                        r_first <= 1'b0;
                    end
                end
                c_st_next: begin
                    if (w_in_dummy) begin
                        bus.adc_word     <= DUMMY_WORD;
                        r_state          <= c_st_start;
                        bus.adc_initiate <= 1'b1;
                    end else begin
                        ready <= 1'b1;
                        if (!run || w_none) begin
                            r_state <= c_st_idle;
                            r_first <= 1'b1;
                        end else begin
                            r_cur            <= w_next_ch;
                            bus.adc_word     <= ctrl_word(w_next_ch, cfg_range, cfg_coding);
                            r_state          <= c_st_start;
                            bus.adc_initiate <= 1'b1;
                        end
                    end
                end
                c_st_idle: begin
                    if (run && !w_none) begin
                        r_cur            <= w_next_ch;
                        bus.adc_word     <= ctrl_word(w_next_ch, cfg_range, cfg_coding);
                        r_state          <= c_st_start;
                        bus.adc_initiate <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_wait_idle;
                end
            endcase
        end
    end

    // Result decode and per-channel bank; a clear is applied before the set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            frame_err <= 1'b0;
            res_ch    <= '0;
            res_data  <= '0;
            ch_data   <= '0;
            ch_valid  <= '0;
        end else begin
            res_valid <= 1'b0;
            frame_err <= 1'b0;
            ch_valid  <= w_valid_kept;
            if (w_capture) begin
                if (bus.adc_result[c_rs_err]) begin
                    frame_err <= 1'b1;
                end else begin
                    res_valid                              <= 1'b1;
                    res_ch                                 <= w_id;
                    res_data                               <= w_data;
                    ch_data[int'(w_id)*RES_BITS +: RES_BITS] <= w_data;
                    ch_valid                               <= w_valid_kept | (8'd1 << w_id);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ad79x8_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ad79x8_sequencer
//  Description : Bench for ad79x8_sequencer with a behavioural interface
//                block / AD79X8 model that echoes the previous frame's ADD.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ad79x8_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, cfg_range, cfg_coding, ch_clr;
    logic [7:0]  en_mask;

    logic        ready, res_valid, frame_err;
    logic [2:0]  res_ch;
    logic [11:0] res_data;
    logic [95:0] ch_data;
    logic [7:0]  ch_valid;

    logic        ready8, res_valid8, frame_err8;
    logic [2:0]  res_ch8;
    logic [7:0]  res_data8;
    logic [63:0] ch_data8;
    logic [7:0]  ch_valid8;

    ad79x8_sequencer_if bus ();
    ad79x8_sequencer_if bus8 ();

    assign bus8.adc_cs     = bus.adc_cs;
    assign bus8.adc_result = bus.adc_result;

    always #5 clk = ~clk;

    ad79x8_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .en_mask(en_mask),
        .cfg_range(cfg_range), .cfg_coding(cfg_coding), .ch_clr(ch_clr),
        .bus(bus), .ready(ready), .res_valid(res_valid), .res_ch(res_ch),
        .res_data(res_data), .ch_data(ch_data), .ch_valid(ch_valid),
        .frame_err(frame_err)
    );

    ad79x8_sequencer #(.RES_BITS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .run(run), .en_mask(en_mask),
        .cfg_range(cfg_range), .cfg_coding(cfg_coding), .ch_clr(ch_clr),
        .bus(bus8), .ready(ready8), .res_valid(res_valid8), .res_ch(res_ch8),
        .res_data(res_data8), .ch_data(ch_data8), .ch_valid(ch_valid8),
        .frame_err(frame_err8)
    );

    int          errors = 0;
    int          checks = 0;
    int          frames_done = 0;
    int          n_ferr = 0;
    logic [15:0] sb[$];
    logic [15:0] word_log[$];
    logic        exp_first = 1'b1;
    logic [95:0] exp_bank = '0;
    logic [7:0]  exp_cv = '0;
    logic        inj_pending = 1'b0;
    logic [15:0] inj_word = '0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Interface block + device model: 16-cycle frames, result echoes the
    // ADD of the previous frame; expectations are queued at frame start.
    initial begin : g_model
        logic [15:0] w, r;
        logic [2:0]  prev_add;
        bus.adc_cs     = 1'b1;
        bus.adc_result = '0;
        prev_add       = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.adc_initiate && bus.adc_cs) begin
                w = bus.adc_word;
                word_log.push_back(w);
                if (inj_pending) begin
                    r = inj_word;
                    inj_pending = 1'b0;
                end else begin
                    r = {1'b0, prev_add, 12'($urandom_range(0, 4095))};
                end
                prev_add = w[12:10];
                if (w != 16'hFFFF) begin
                    if (exp_first) exp_first = 1'b0;
                    else           sb.push_back(r);
                end
                bus.adc_cs = 1'b0;
                repeat (16) @(posedge clk);
                #1;
                bus.adc_result = r;
                bus.adc_cs     = 1'b1;
                frames_done++;
            end
        end
    end

    // Output monitor: every result or error pulse must match the queue head
    always @(negedge clk) begin : g_monitor
        logic [15:0] r;
        if (rst_n && (res_valid || frame_err)) begin
            check("lockstep", {res_valid8, frame_err8}, {res_valid, frame_err});
            if (sb.size() == 0) begin
                check("sb_unexpected", 1, 0);
            end else begin
                r = sb.pop_front();
                if (r[15]) begin
                    n_ferr++;
                    check("ferr", frame_err, 1'b1);
                    check("ferr_novalid", res_valid, 1'b0);
                    check("bank_keep", ch_data, exp_bank);
                end else begin
                    check("res_valid", res_valid, 1'b1);
                    check("res_ch", res_ch, r[14:12]);
                    check("res_data", res_data, r[11:0]);
                    check("res_data8", res_data8, r[11:4]);
                    exp_bank[int'(r[14:12])*12 +: 12] = r[11:0];
                    exp_cv[r[14:12]] = 1'b1;
                    check("bank", ch_data, exp_bank);
                end
            end
        end
    end

    task automatic wait_frames(input int n);
        int target, cyc;
        target = frames_done + n;
        cyc    = 0;
        while (frames_done < target && cyc < 60 * n) begin
            @(negedge clk);
            cyc++;
        end
        if (frames_done < target) check("timeout_frames", frames_done, target);
    endtask

    task automatic wait_cs(input logic lvl);
        int cyc;
        cyc = 0;
        while (bus.adc_cs !== lvl && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (bus.adc_cs !== lvl) check("timeout_cs", bus.adc_cs, lvl);
    endtask

    initial begin : g_watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : g_main
        int   idx, s;
        logic bad;
        rst_n = 1'b0; run = 1'b0; en_mask = 8'h00;
        cfg_range = 1'b0; cfg_coding = 1'b0; ch_clr = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_initiate", bus.adc_initiate, 1'b0);
        check("rst_word", bus.adc_word, 16'hFFFF);
        check("rst_ready", ready, 1'b0);
        check("rst_outputs", {res_valid, frame_err, res_ch, res_data}, '0);
        check("rst_bank", {ch_data, ch_valid}, '0);

        // Power-up dummy frames then channel 0
        run = 1'b1; en_mask = 8'h01;
        rst_n = 1'b1;
        wait_frames(1);
        check("ready_during_dummy", ready, 1'b0);
        wait_frames(3);
        repeat (6) @(negedge clk);
        check("word0", word_log[0], 16'hFFFF);
        check("word1", word_log[1], 16'hFFFF);
        check("word2", word_log[2], 16'h8300);
        check("word3", word_log[3], 16'h8300);
        check("ready_after_dummy", ready, 1'b1);
        check("ch_valid_ch0", ch_valid, 8'h01);

        // Round robin over A4 with range/coding set
        wait_cs(1'b0);
        en_mask = 8'hA4; cfg_range = 1'b1; cfg_coding = 1'b1;
        idx = word_log.size();
        wait_frames(2);
        repeat (5) @(negedge clk);
        ch_clr = 1'b1; exp_cv = '0;
        @(negedge clk);
        ch_clr = 1'b0;
        wait_frames(3);
        repeat (6) @(negedge clk);
        check("rr_w0", word_log[idx],   16'h8B30);
        check("rr_w1", word_log[idx+1], 16'h9730);
        check("rr_w2", word_log[idx+2], 16'h9F30);
        check("rr_w3", word_log[idx+3], 16'h8B30);
        check("ch_valid_a4", ch_valid, 8'hA4);

        // Injected results: good word, error word, 8-bit data slice
        inj_word = 16'h5ABC; inj_pending = 1'b1;
        wait_frames(2);
        repeat (5) @(negedge clk);
        check("inj_ch", res_ch, 3'd5);
        check("inj_data", res_data, 12'hABC);
        check("inj_bank5", ch_data[5*12 +: 12], 12'hABC);
        s = n_ferr;
        inj_word = 16'hD000; inj_pending = 1'b1;
        wait_frames(2);
        repeat (5) @(negedge clk);
        check("ferr_count", n_ferr, s + 1);
        inj_word = 16'h2F3C; inj_pending = 1'b1;
        wait_frames(2);
        repeat (5) @(negedge clk);
        check("res8_slice", res_data8, 8'hF3);
        check("res12_slice", res_data, 12'hF3C);

        // ch_clr in the same cycle as a channel 3 capture
        en_mask = 8'h08;
        wait_frames(3);
        wait_cs(1'b0);
        wait_cs(1'b1);
        @(negedge clk);
        @(negedge clk);
        ch_clr = 1'b1; exp_cv = '0;
        @(negedge clk);
        ch_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("clr_same_cycle", ch_valid, 8'h08);
        check("clr_model", ch_valid, exp_cv);

        // run falls mid-frame: frame completes and is captured, then idle
        en_mask = 8'hFF;
        wait_frames(2);
        wait_cs(1'b0);
        run = 1'b0;
        wait_frames(1);
        repeat (6) @(negedge clk);
        s = word_log.size();
        repeat (60) @(negedge clk);
        check("idle_no_frame", word_log.size(), s);
        check("idle_initiate", bus.adc_initiate, 1'b0);
        exp_first = 1'b1;
        run = 1'b1;
        wait_frames(3);
        repeat (6) @(negedge clk);

        // Reset pulsed mid-frame
        wait_cs(1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        sb.delete(); exp_first = 1'b1; exp_bank = '0; exp_cv = '0;
        #1;
        check("midrst_ready", ready, 1'b0);
        check("midrst_word", bus.adc_word, 16'hFFFF);
        check("midrst_bank", {ch_data, ch_valid}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        idx = word_log.size();
        bad = 1'b0;
        for (int i = 0; i < 40 && bus.adc_cs !== 1'b1; i++) begin
            if (bus.adc_initiate !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        check("midrst_init_hold", bad, 1'b0);
        wait_frames(3);
        repeat (6) @(negedge clk);
        check("midrst_w0", word_log[idx],   16'hFFFF);
        check("midrst_w1", word_log[idx+1], 16'hFFFF);
        check("midrst_w2", word_log[idx+2], 16'h8330);
        check("midrst_ready_up", ready, 1'b1);

        // Drain
        run = 1'b0;
        repeat (60) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
